// File: rtl/cp0_irq_ctrl.sv
// CP0 register file, Count/Compare timer and prioritised interrupt/exception redirect at commit.
// Redirect is combinational in the commit cycle, state updates land one cycle later; never stalls.
`ifndef causeERET
`define causeERET 5'h1f
`endif

module cp0_irq_ctrl #(
   parameter int          NUM_HW_IRQ   = 5,
   parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
   parameter logic [31:0] PRID_VALUE   = 32'hDEAD_BEEF,
   parameter bit          TIMER_EN     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [4:0]            reg_num,
   input  logic [31:0]           wr_data,
   output logic [31:0]           rd_data,
   input  logic [NUM_HW_IRQ-1:0] hw_irq,
   input  logic                  commit_valid,
   input  logic [31:0]           commit_pc,
   input  logic                  commit_bd,
   input  logic                  exc_valid,
   input  logic [4:0]            exc_cause,
   output logic                  jump,
   output logic [31:0]           jump_addr,
   output logic                  irq_pending
);

   localparam logic [4:0] CAUSE_ERET = `causeERET;

   logic [31:0]           count_q, count_d;
   logic [31:0]           compare_q, compare_d;
   logic                  tpend_q, tpend_d;
   logic [5:0]            im_q, im_d;
   logic                  exl_q, exl_d;
   logic                  ie_q, ie_d;
   logic                  bd_q, bd_d;
   logic [4:0]            code_q, code_d;
   logic [31:0]           epc_q, epc_d;
   logic [NUM_HW_IRQ-1:0] hw_q, hw_d;

   logic [5:0] ip;
   logic       take_irq, take_exc, take_eret, wr_ok;

   // IP[15:10] as a 6-bit vector: external lines low, timer on top
   always_comb begin
      ip = '0;
      for (int k = 0; k < NUM_HW_IRQ; k++) begin
         ip[k] = hw_q[k];
      end
      ip[5] = TIMER_EN ? tpend_q : 1'b0;
   end

   always_comb begin
      irq_pending = ~reset & ie_q & ~exl_q & (|(ip & im_q));
      take_irq    = irq_pending & commit_valid;
      take_exc    = ~reset & ~take_irq & exc_valid & (exc_cause != CAUSE_ERET);
      take_eret   = ~reset & ~take_irq & exc_valid & (exc_cause == CAUSE_ERET);
      jump        = take_irq | take_exc | take_eret;
      jump_addr   = take_eret ? epc_q : HANDLER_ADDR;
      wr_ok       = wr_en & ~jump;
   end

   always_comb begin
      rd_data = '0;
      case (reg_num)
         5'd9:    rd_data = TIMER_EN ? count_q : 32'd0;
         5'd11:   rd_data = TIMER_EN ? compare_q : 32'd0;
         5'd12:   rd_data = {16'd0, im_q, 8'd0, exl_q, ie_q};
         5'd13:   rd_data = {bd_q, 15'd0, ip, 3'd0, code_q, 2'd0};
         5'd14:   rd_data = epc_q;
         5'd15:   rd_data = PRID_VALUE;
         default: rd_data = '0;
      endcase
   end

   always_comb begin
      count_d   = count_q;
      compare_d = compare_q;
      tpend_d   = tpend_q;
      im_d      = im_q;
      exl_d     = exl_q;
      ie_d      = ie_q;
      bd_d      = bd_q;
      code_d    = code_q;
      epc_d     = epc_q;
      hw_d      = hw_irq;

      if (TIMER_EN) begin
         count_d = count_q + 32'd1;
         if (count_q == compare_q) begin
            tpend_d = 1'b1;
         end
      end

      if (wr_ok) begin
         case (reg_num)
            5'd9: begin
               if (TIMER_EN) count_d = wr_data;
            end
            5'd11: begin
               if (TIMER_EN) begin
                  compare_d = wr_data;
                  tpend_d   = 1'b0;
               end
            end
            5'd12: begin
               im_d  = wr_data[15:10];
               exl_d = wr_data[1];
               ie_d  = wr_data[0];
            end
            5'd14:   epc_d = wr_data;
            default: ;
         endcase
      end

      // EPC points at the branch when the victim sits in a delay slot
      if (take_irq | take_exc) begin
         exl_d  = 1'b1;
         bd_d   = commit_bd;
         epc_d  = commit_bd ? (commit_pc - 32'd4) : commit_pc;
         code_d = take_irq ? 5'd0 : exc_cause;
      end
      if (take_eret) begin
         exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q   <= '0;
         compare_q <= TIMER_EN ? 32'hFFFF_FFFF : 32'd0;
         tpend_q   <= 1'b0;
         im_q      <= 6'h3F;
         exl_q     <= 1'b0;
         ie_q      <= 1'b1;
         bd_q      <= 1'b0;
         code_q    <= '0;
         epc_q     <= '0;
         hw_q      <= '0;
      end else begin
         count_q   <= count_d;
         compare_q <= compare_d;
         tpend_q   <= tpend_d;
         im_q      <= im_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         code_q    <= code_d;
         epc_q     <= epc_d;
         hw_q      <= hw_d;
      end
   end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Randomised and directed checks of cp0_irq_ctrl against an architectural-level model.
module tb_cp0_irq_ctrl;

   localparam logic [4:0]  ERET    = 5'h1f;
   localparam logic [31:0] HANDLER = 32'h0000_4180;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic [4:0]  reg_num;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic [4:0]  hw_irq;
   logic        commit_valid;
   logic [31:0] commit_pc;
   logic        commit_bd;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic        jump;
   logic [31:0] jump_addr;
   logic        irq_pending;

   int total = 0;
   int bad   = 0;

   cp0_irq_ctrl dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .reg_num(reg_num), .wr_data(wr_data),
      .rd_data(rd_data), .hw_irq(hw_irq), .commit_valid(commit_valid),
      .commit_pc(commit_pc), .commit_bd(commit_bd), .exc_valid(exc_valid),
      .exc_cause(exc_cause), .jump(jump), .jump_addr(jump_addr), .irq_pending(irq_pending)
   );

   always #5 clk = ~clk;

   // architectural state of the model
   logic [31:0] m_count, m_compare, m_epc;
   logic        m_pend, m_exl, m_ie, m_bd;
   logic [5:0]  m_im;
   logic [4:0]  m_code, m_hw;

   task automatic m_reset();
      m_count = 0; m_compare = 32'hFFFF_FFFF; m_epc = 0; m_pend = 0;
      m_exl = 0; m_ie = 1; m_bd = 0; m_im = 6'h3F; m_code = 0; m_hw = 0;
   endtask

   function automatic logic m_irq();
      logic [5:0] ipv;
      ipv = {m_pend, m_hw};
      return m_ie && !m_exl && ((ipv & m_im) != 0);
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      logic [31:0] v;
      v = 0;
      case (r)
         5'd9:  v = m_count;
         5'd11: v = m_compare;
         5'd12: v = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
         5'd13: v = (32'(m_bd) << 31) | (32'({m_pend, m_hw}) << 10) | (32'(m_code) << 2);
         5'd14: v = m_epc;
         5'd15: v = 32'hDEAD_BEEF;
         default: v = 0;
      endcase
      return v;
   endfunction

   // which event commit would take this cycle: 0 none, 1 irq, 2 exception, 3 eret
   function automatic int m_event();
      if (reset) return 0;
      if (m_irq() && commit_valid) return 1;
      if (exc_valid && exc_cause != ERET) return 2;
      if (exc_valid) return 3;
      return 0;
   endfunction

   task automatic m_update();
      int ev;
      logic [31:0] n_count;
      logic        n_pend;
      if (reset) begin
         m_reset();
         return;
      end
      ev      = m_event();
      n_count = m_count + 1;
      n_pend  = m_pend || (m_count == m_compare);
      if (wr_en && ev == 0) begin
         if (reg_num == 9)  n_count = wr_data;
         if (reg_num == 11) begin m_compare = wr_data; n_pend = 0; end
         if (reg_num == 12) begin m_im = wr_data[15:10]; m_exl = wr_data[1]; m_ie = wr_data[0]; end
         if (reg_num == 14) m_epc = wr_data;
      end
      if (ev == 1 || ev == 2) begin
         m_exl  = 1;
         m_bd   = commit_bd;
         m_epc  = commit_bd ? commit_pc - 4 : commit_pc;
         m_code = (ev == 1) ? 5'd0 : exc_cause;
      end
      if (ev == 3) m_exl = 0;
      m_count = n_count;
      m_pend  = n_pend;
      m_hw    = hw_irq;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic rd(input logic [4:0] r, input logic [31:0] exp, input string name);
      reg_num = r;
      #1;
      chk(name, rd_data, exp);
   endtask

   // compare all outputs against the model, then advance one clock
   task automatic step();
      int ev;
      #1;
      ev = m_event();
      chk("jump", 32'(jump), 32'(ev != 0));
      if (ev != 0) chk("jump_addr", jump_addr, (ev == 3) ? m_epc : HANDLER);
      chk("irq_pending", 32'(irq_pending), 32'(!reset && m_irq()));
      chk("rd_data", rd_data, m_read(reg_num));
      @(posedge clk);
      m_update();
      @(negedge clk);
   endtask

   task automatic idle();
      wr_en = 0; reg_num = 0; wr_data = 0; commit_valid = 0; commit_pc = 0;
      commit_bd = 0; exc_valid = 0; exc_cause = 0;
   endtask

   initial begin
      clk = 0; hw_irq = 0; reset = 1;
      idle();
      m_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;

      // reset values and read-only PrId
      rd(12, 32'h0000_FC01, "sr_rst"); rd(13, 0, "cause_rst"); rd(14, 0, "epc_rst");
      step();
      rd(15, 32'hDEAD_BEEF, "prid");
      chk("irqp_rst", 32'(irq_pending), 0);
      wr_en = 1; reg_num = 15; wr_data = 32'h1234_5678;
      step();
      wr_en = 0;
      rd(15, 32'hDEAD_BEEF, "prid_ro");
      step();

      // exception in a delay slot
      commit_valid = 1; commit_pc = 32'h3000; commit_bd = 1; exc_valid = 1; exc_cause = 5'd4;
      #1; chk("exc_jump", 32'(jump), 1); chk("exc_addr", jump_addr, HANDLER);
      step();
      idle();
      rd(14, 32'h2FFC, "exc_epc"); rd(13, 32'h8000_0010, "exc_cause"); rd(12, 32'h0000_FC03, "exc_sr");
      step();

      // ERET back, then hardware interrupt on line 0
      exc_valid = 1; exc_cause = ERET;
      #1; chk("eret_addr", jump_addr, 32'h2FFC);
      step();
      idle();
      rd(12, 32'h0000_FC01, "eret_sr");
      hw_irq = 5'b00001;
      #1; chk("irq_lat0", 32'(irq_pending), 0);
      step();
      commit_valid = 1; commit_pc = 32'h5000;
      #1; chk("irq_lat1", 32'(irq_pending), 1); chk("irq_jump", 32'(jump), 1);
      chk("irq_addr", jump_addr, HANDLER);
      step();
      idle();
      rd(14, 32'h5000, "irq_epc"); rd(13, 32'h0000_0400, "irq_cause"); rd(12, 32'h0000_FC03, "irq_sr");
      step();
      exc_valid = 1; exc_cause = ERET;
      #1; chk("eret2_addr", jump_addr, 32'h5000);
      step();
      idle();
      #1; chk("retake", 32'(irq_pending), 1);
      wr_en = 1; reg_num = 12; wr_data = 32'h0000_F801;
      step();
      idle();
      commit_valid = 1;
      #1; chk("masked_nojump", 32'(jump), 0);
      rd(13, 32'h0000_0400, "masked_ip");
      step();
      idle();
      hw_irq = 0;
      wr_en = 1; reg_num = 12; wr_data = 32'h0000_FC01;
      step();

      // timer: Compare=10, Count=0
      wr_en = 1; reg_num = 11; wr_data = 10;
      step();
      reg_num = 9; wr_data = 0;
      step();
      wr_en = 0;
      for (int k = 0; k < 12; k++) begin
         rd(9, 32'(k), "count");
         reg_num = 13; #1;
         chk("ip15", 32'(rd_data[15]), 32'(k >= 11));
         step();
      end
      wr_en = 1; reg_num = 11; wr_data = 32'hFFFF_FFFF;
      step();
      wr_en = 0;
      reg_num = 13; #1; chk("ip15_clr", 32'(rd_data[15]), 0);
      step();

      // interrupt preempts exception; same-cycle write flushed
      hw_irq = 5'b00010;
      step();
      commit_valid = 1; commit_pc = 32'h6000; exc_valid = 1; exc_cause = 5'd8;
      wr_en = 1; reg_num = 14; wr_data = 32'hAAAA_AAA0;
      #1; chk("pre_jump", 32'(jump), 1); chk("pre_addr", jump_addr, HANDLER);
      step();
      idle();
      rd(13, 32'h0000_0800, "pre_cause"); rd(14, 32'h6000, "pre_epc");
      step();
      exc_valid = 1; exc_cause = ERET;
      #1; chk("pre_eret", jump_addr, 32'h6000);
      step();
      idle(); hw_irq = 0;
      repeat (2) step();

      // randomised traffic
      for (int i = 0; i < 4000; i++) begin
         int pick;
         reset = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 7) == 0) hw_irq[$urandom_range(0, 4)] ^= 1'b1;
         commit_valid = ($urandom_range(0, 2) != 0);
         commit_pc    = {$urandom(), 2'b00} & 32'hFFFF_FFFC;
         commit_bd    = 1'($urandom_range(0, 1));
         exc_valid    = ($urandom_range(0, 5) == 0);
         exc_cause    = ($urandom_range(0, 2) == 0) ? ERET : 5'($urandom_range(0, 31));
         wr_en        = ($urandom_range(0, 3) == 0);
         pick         = $urandom_range(0, 7);
         case (pick)
            0: reg_num = 9;   1: reg_num = 11;  2: reg_num = 12;  3: reg_num = 13;
            4: reg_num = 14;  5: reg_num = 15;  6: reg_num = 0;
            default: reg_num = 5'($urandom_range(0, 31));
         endcase
         wr_data = $urandom();
         if (reg_num == 11) wr_data = m_count + 32'($urandom_range(0, 20));
         if (reg_num == 9)  wr_data = m_compare - 32'($urandom_range(0, 20));
         if (reg_num == 12 && $urandom_range(0, 1) == 1) wr_data[1:0] = 2'b01;
         step();
      end
      reset = 0;
      idle();
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
